// File: rtl/tl_arb_pkg.sv
// Shared TileLink-UL constants, arbiter state encoding and the beat-count helper
// used by the two-requester arbiter.
package tl_arb_pkg;

  localparam logic [2:0] OP_PUT_FULL        = 3'd0;
  localparam logic [2:0] OP_PUT_PARTIAL     = 3'd1;
  localparam logic [2:0] OP_GET             = 3'd4;
  localparam logic [2:0] OP_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] OP_ACCESS_ACK_DATA = 3'd1;

  // An 8-byte transfer on a 32-bit bus takes two beats.
  localparam logic [1:0] SIZE_TWO_BEAT = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_BURST = 2'd2
  } arb_state_e;

  // A and D opcodes overlap numerically, so the caller says which channel it is.
  function automatic logic [1:0] beats(input logic [2:0] opcode,
                                       input logic [1:0] size,
                                       input logic       d_chan);
    logic has_data;
    has_data = d_chan ? (opcode == OP_ACCESS_ACK_DATA)
                      : (opcode == OP_PUT_FULL || opcode == OP_PUT_PARTIAL);
    return (has_data && size == SIZE_TWO_BEAT) ? 2'd2 : 2'd1;
  endfunction

endpackage

// File: rtl/tl_arb_out_cnt.sv
// Outstanding-transaction counter for one requester: counts completed A requests
// minus completed D responses, tracking multi-beat responses with its own beat flag.
module tl_arb_out_cnt #(
  parameter int MAX_OUT = 4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic a_last_fire,
  input  logic d_fire,
  input  logic d_two_beat,
  output logic below_max
);

  localparam int CNT_W = 4;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             d_beat_q, d_beat_d;
  logic             d_last_fire;

  // NOTE: every signal gets a default at the top so no path leaves it unassigned (no latch).
  always_comb begin
    d_beat_d    = d_beat_q;
    d_last_fire = 1'b0;
    cnt_d       = cnt_q;
    if (d_fire) begin
      if (d_two_beat && !d_beat_q) begin
        d_beat_d = 1'b1;
      end else begin
        d_beat_d    = 1'b0;
        d_last_fire = 1'b1;
      end
    end
    if (a_last_fire && !d_last_fire) begin
      if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
    end else if (d_last_fire && !a_last_fire) begin
      if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      d_beat_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      d_beat_q <= d_beat_d;
    end
  end

  assign below_max = (cnt_q < CNT_W'(MAX_OUT));

endmodule

// File: rtl/tl_ul_arb2.sv
// Two-requester TileLink-UL arbiter onto one slave port; round-robin grant locked
// through HOLD and Put bursts. Define TL_ARB_FIXED_PRIO_EN for fixed m0 priority.
module tl_ul_arb2
  import tl_arb_pkg::*;
#(
  parameter int SRC_W   = 2,
  parameter int MAX_OUT = 4
) (
  input  logic              clock,
  input  logic              reset_n,

  input  logic              m0_a_valid,
  output logic              m0_a_ready,
  input  logic [2:0]        m0_a_opcode,
  input  logic [2:0]        m0_a_param,
  input  logic [1:0]        m0_a_size,
  input  logic [SRC_W-1:0]  m0_a_source,
  input  logic [31:0]       m0_a_address,
  input  logic [3:0]        m0_a_mask,
  input  logic [31:0]       m0_a_data,

  input  logic              m1_a_valid,
  output logic              m1_a_ready,
  input  logic [2:0]        m1_a_opcode,
  input  logic [2:0]        m1_a_param,
  input  logic [1:0]        m1_a_size,
  input  logic [SRC_W-1:0]  m1_a_source,
  input  logic [31:0]       m1_a_address,
  input  logic [3:0]        m1_a_mask,
  input  logic [31:0]       m1_a_data,

  output logic              s_a_valid,
  input  logic              s_a_ready,
  output logic [2:0]        s_a_opcode,
  output logic [2:0]        s_a_param,
  output logic [1:0]        s_a_size,
  output logic [SRC_W:0]    s_a_source,
  output logic [31:0]       s_a_address,
  output logic [3:0]        s_a_mask,
  output logic [31:0]       s_a_data,

  input  logic              s_d_valid,
  output logic              s_d_ready,
  input  logic [2:0]        s_d_opcode,
  input  logic [1:0]        s_d_size,
  input  logic [SRC_W:0]    s_d_source,
  input  logic [31:0]       s_d_data,
  input  logic              s_d_error,

  output logic              m0_d_valid,
  input  logic              m0_d_ready,
  output logic [2:0]        m0_d_opcode,
  output logic [1:0]        m0_d_size,
  output logic [SRC_W-1:0]  m0_d_source,
  output logic [31:0]       m0_d_data,
  output logic              m0_d_error,

  output logic              m1_d_valid,
  input  logic              m1_d_ready,
  output logic [2:0]        m1_d_opcode,
  output logic [1:0]        m1_d_size,
  output logic [SRC_W-1:0]  m1_d_source,
  output logic [31:0]       m1_d_data,
  output logic              m1_d_error
);

  arb_state_e state_q;
  logic       grant_q;
  logic [1:0] beat_cnt_q;

  logic [1:0] below_max;
  logic [1:0] elig;
  logic       sel;
  logic       sel_valid;
  logic [1:0] a_beats;
  logic       a_fire;
  logic       a_last;
  logic       d_idx;
  logic       d_fire;
  logic       d_two_beat;

  assign elig[0] = m0_a_valid & below_max[0];
  assign elig[1] = m1_a_valid & below_max[1];

`ifndef TL_ARB_FIXED_PRIO_EN
  // Preferred requester when both are eligible: the one not granted last.
  logic rr_ptr_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)             rr_ptr_q <= 1'b0;
    else if (a_fire && a_last) rr_ptr_q <= ~sel;
  end
`endif

  always_comb begin
    sel       = grant_q;
    sel_valid = 1'b0;
    if (state_q == ST_IDLE) begin
`ifdef TL_ARB_FIXED_PRIO_EN
      sel = ~elig[0];
`else
      sel = (elig[0] && elig[1]) ? rr_ptr_q : ~elig[0];
`endif
      sel_valid = |elig;
    end else begin
      // A locked grant ignores the outstanding limit; its count cannot rise until it fires.
      sel_valid = sel ? m1_a_valid : m0_a_valid;
    end
  end

  // Handshake outputs are gated by reset_n so they drop as soon as reset asserts.
  assign s_a_valid   = reset_n & sel_valid;
  assign m0_a_ready  = reset_n & sel_valid & ~sel & s_a_ready;
  assign m1_a_ready  = reset_n & sel_valid &  sel & s_a_ready;

  assign s_a_opcode  = sel ? m1_a_opcode  : m0_a_opcode;
  assign s_a_param   = sel ? m1_a_param   : m0_a_param;
  assign s_a_size    = sel ? m1_a_size    : m0_a_size;
  assign s_a_source  = {sel, (sel ? m1_a_source : m0_a_source)};
  assign s_a_address = sel ? m1_a_address : m0_a_address;
  assign s_a_mask    = sel ? m1_a_mask    : m0_a_mask;
  assign s_a_data    = sel ? m1_a_data    : m0_a_data;

  assign a_beats = beats(s_a_opcode, s_a_size, 1'b0);
  assign a_fire  = s_a_valid & s_a_ready;
  // beat_cnt_q is zero outside BURST, so this also flags single-beat requests.
  assign a_last  = ((beat_cnt_q + 2'd1) == a_beats);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      grant_q    <= 1'b0;
      beat_cnt_q <= 2'd0;
    end else begin
      case (state_q)
        ST_IDLE, ST_HOLD: begin
          if (a_fire) begin
            grant_q <= sel;
            if (a_last) begin
              state_q <= ST_IDLE;
            end else begin
              state_q    <= ST_BURST;
              beat_cnt_q <= beat_cnt_q + 2'd1;
            end
          end else if (sel_valid) begin
            state_q <= ST_HOLD;
            grant_q <= sel;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_BURST: begin
          if (a_fire) begin
            if (a_last) begin
              state_q    <= ST_IDLE;
              beat_cnt_q <= 2'd0;
            end else begin
              beat_cnt_q <= beat_cnt_q + 2'd1;
            end
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          beat_cnt_q <= 2'd0;
        end
      endcase
    end
  end

  // D channel: steered by the source MSB, no buffering.
  assign d_idx      = s_d_source[SRC_W];
  assign m0_d_valid = reset_n & s_d_valid & ~d_idx;
  assign m1_d_valid = reset_n & s_d_valid &  d_idx;
  assign s_d_ready  = reset_n & (d_idx ? m1_d_ready : m0_d_ready);
  assign d_fire     = s_d_valid & s_d_ready;
  assign d_two_beat = (beats(s_d_opcode, s_d_size, 1'b1) == 2'd2);

  assign m0_d_opcode = s_d_opcode;
  assign m0_d_size   = s_d_size;
  assign m0_d_source = s_d_source[SRC_W-1:0];
  assign m0_d_data   = s_d_data;
  assign m0_d_error  = s_d_error;
  assign m1_d_opcode = s_d_opcode;
  assign m1_d_size   = s_d_size;
  assign m1_d_source = s_d_source[SRC_W-1:0];
  assign m1_d_data   = s_d_data;
  assign m1_d_error  = s_d_error;

  tl_arb_out_cnt #(.MAX_OUT(MAX_OUT)) u_cnt0 (
    .clock       (clock),
    .reset_n     (reset_n),
    .a_last_fire (a_fire & a_last & ~sel),
    .d_fire      (d_fire & ~d_idx),
    .d_two_beat  (d_two_beat),
    .below_max   (below_max[0])
  );

  tl_arb_out_cnt #(.MAX_OUT(MAX_OUT)) u_cnt1 (
    .clock       (clock),
    .reset_n     (reset_n),
    .a_last_fire (a_fire & a_last & sel),
    .d_fire      (d_fire & d_idx),
    .d_two_beat  (d_two_beat),
    .below_max   (below_max[1])
  );

endmodule

// File: doc/tl_ul_arb2.md
Name: tl_ul_arb2

Overview:
- Two-requester TileLink-UL arbiter onto one 32-bit slave port (core fetch/LSU sharing the same A/D port).
- Round-robin A-channel grant, held for whole multi-beat Put bursts; D-channel steered back by source MSB.
- Per-requester outstanding-transaction counters throttle each requester.

Parameters:
- SRC_W, 2, requester-side source width; slave source width is SRC_W+1, MSB = requester index.
- MAX_OUT, 4, max outstanding transactions per requester (1..15).

Ports:
- clock  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- m{0,1}_a_valid / m{0,1}_a_ready  in / out  1  requester A handshake.
- m{0,1}_a_opcode, _a_param  in  3  TL opcode/param.
- m{0,1}_a_size  in  2  log2 bytes (0..3; 3 = 8 B = 2 beats).
- m{0,1}_a_source  in  SRC_W  requester source ID.
- m{0,1}_a_address / _a_data  in  32  address, write data.
- m{0,1}_a_mask  in  4  byte lanes.
- s_a_valid / s_a_ready  out / in  1  slave A handshake.
- s_a_opcode, s_a_param, s_a_size, s_a_address, s_a_mask, s_a_data  out  as above  muxed A fields.
- s_a_source  out  SRC_W+1  {grant index, requester source}.
- s_d_valid / s_d_ready  in / out  1  slave D handshake.
- s_d_opcode  in  3; s_d_size  in  2; s_d_source  in  SRC_W+1; s_d_data  in  32; s_d_error  in  1.
- m{0,1}_d_valid / m{0,1}_d_ready  out / in  1  requester D handshake.
- m{0,1}_d_opcode, _d_size, _d_source, _d_data, _d_error  out  D fields; source MSB stripped.

Behaviour:
- Eligible(i) = mi_a_valid && out_cnt[i] < MAX_OUT (a burst in progress ignores the limit).
- States: IDLE, HOLD, BURST. Reset: IDLE, rr_ptr=0 (m0 preferred first), out_cnt=0, beat_cnt=0, all valid/ready outputs 0.
- IDLE: pick eligible requester, rr_ptr favours the one not last granted; drive s_a_* combinationally. Fire single-beat -> stay IDLE, rr_ptr flips to other. No fire -> HOLD with grant frozen; TL valid stability is preserved. Fire first beat of PutFull/PutPartial with size 3 -> BURST, beat_cnt=1.
- HOLD: grant fixed until fire, then as in IDLE.
- BURST: grant fixed; only granted mi_a_ready follows s_a_ready; last beat fire -> IDLE, rr_ptr flips.
- Non-granted mi_a_ready = 0 at all times.
- out_cnt[i]: +1 on last A beat fire of i; -1 on last D beat fire to i. AccessAckData size 3 = 2 beats; separate D beat counter. Simultaneous inc/dec -> unchanged. Saturates at 0, never underflows.
- D: s_d_source MSB selects mi_d_valid; s_d_ready = selected mi_d_ready. Combinational, zero latency, no D buffering.
- A path zero added latency; only the grant state is registered.
- Reset mid-burst: all state cleared immediately; in-flight responses are not tracked.

Optional Feature:
- TL_ARB_FIXED_PRIO_EN: defined -> m0 always wins when eligible; rr_ptr is removed. Undefined -> round-robin as above. Burst and HOLD locking are identical in both builds.

Decomposition:
- Package tl_arb_pkg: TL opcode constants (PutFull=0, PutPartial=1, Get=4, AccessAck=0, AccessAckData=1), state enum, function beats(opcode,size).
- Sub-module tl_arb_out_cnt: one instance per requester, holds the outstanding counter plus its D beat counter.

Test Plan:
- Both a_valid=1, Get size 2, s_a_ready=1 -> grants alternate m0,m1,m0; s_a_source MSB 0,1,0.
- m1 PutFull size 3 (2 beats), m0 requesting -> m1 holds both beats, m0 granted on the next cycle.
- s_a_ready=0 three cycles while m0 granted, m1 raises valid -> grant stays m0 until fire.
- MAX_OUT=4, m0 issues 4 Gets with no D -> 5th stalls (m0_a_ready=0). One AccessAck with source MSB 0 -> 5th Get fires next cycle.
- AccessAckData size 3, source {1,2'b10} -> m1_d_valid both beats, m1_d_source=2'b10, out_cnt[1] decrements after beat 2.
- reset_n low mid-burst -> s_a_valid=0, out_cnt=0 asynchronously; after release m0 is granted first.
